// File: rtl/sdff_scan_ctrl.sv
// Scan chain of WIDTH cells with a capture/shift/update sequencer and a parallel update register.
// Latency: an automatic cycle holds BUSY for WIDTH+2 clocks, then DONE pulses for one clock. SO is combinational from Q[WIDTH-1].
// Backpressure: none. SE and START are ignored while BUSY; a START held high restarts on the first IDLE edge.
module sdff_scan_ctrl #(
    parameter int                 WIDTH   = 4,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic [WIDTH-1:0] DI,
    input  logic             SI,
    input  logic             SE,
    input  logic             START,
    output logic             SO,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] UQ,
    output logic             BUSY,
    output logic             DONE
);

    localparam int               CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SHIFT   = 2'd2,
        UPDATE  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] q_nxt, uq_nxt, shift_val;
    logic             done_nxt;

    // Cell 0 takes SI, every other cell takes its lower neighbour.
    assign shift_val = {Q[WIDTH-2:0], SI};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        q_nxt     = Q;
        uq_nxt    = UQ;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    state_nxt = CAPTURE;
                end else if (SE) begin
                    q_nxt = shift_val;
                end else begin
                    q_nxt = DI;
                end
            end
            CAPTURE: begin
                q_nxt     = DI;
                cnt_nxt   = '0;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                q_nxt = shift_val;
                if (cnt == LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = UPDATE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            UPDATE: begin
                uq_nxt    = Q;
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
            cnt   <= '0;
            Q     <= RST_VAL;
            UQ    <= RST_VAL;
            DONE  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            Q     <= q_nxt;
            UQ    <= uq_nxt;
            DONE  <= done_nxt;
        end
    end

    assign BUSY = (state != IDLE);
    assign SO   = Q[WIDTH-1];

endmodule

// File: tb/tb_sdff_scan_ctrl.sv
// Directed bench for sdff_scan_ctrl at WIDTH 4, 2 and 7, sharing clock and inputs.
module tb_sdff_scan_ctrl;

    logic        CLK;
    logic        rstn;
    logic [63:0] di;
    logic        si, se, start;

    logic       so4, busy4, done4;
    logic [3:0] q4, uq4;
    logic       so2, busy2, done2;
    logic [1:0] q2, uq2;
    logic       so7, busy7, done7;
    logic [6:0] q7, uq7;

    int n_checks = 0;
    int n_err    = 0;

    sdff_scan_ctrl #(.WIDTH(4), .RST_VAL(4'b1010)) u4 (
        .CLK(CLK), .RSTn(rstn), .DI(di[3:0]), .SI(si), .SE(se), .START(start),
        .SO(so4), .Q(q4), .UQ(uq4), .BUSY(busy4), .DONE(done4)
    );
    sdff_scan_ctrl #(.WIDTH(2)) u2 (
        .CLK(CLK), .RSTn(rstn), .DI(di[1:0]), .SI(si), .SE(se), .START(start),
        .SO(so2), .Q(q2), .UQ(uq2), .BUSY(busy2), .DONE(done2)
    );
    sdff_scan_ctrl #(.WIDTH(7)) u7 (
        .CLK(CLK), .RSTn(rstn), .DI(di[6:0]), .SI(si), .SE(se), .START(start),
        .SO(so7), .Q(q7), .UQ(uq7), .BUSY(busy7), .DONE(done7)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] f_q(input int w);
        case (w)
            2:       f_q = {62'd0, q2};
            7:       f_q = {57'd0, q7};
            default: f_q = {60'd0, q4};
        endcase
    endfunction

    function automatic logic [63:0] f_uq(input int w);
        case (w)
            2:       f_uq = {62'd0, uq2};
            7:       f_uq = {57'd0, uq7};
            default: f_uq = {60'd0, uq4};
        endcase
    endfunction

    function automatic logic f_so(input int w);
        case (w)
            2:       f_so = so2;
            7:       f_so = so7;
            default: f_so = so4;
        endcase
    endfunction

    function automatic logic f_busy(input int w);
        case (w)
            2:       f_busy = busy2;
            7:       f_busy = busy7;
            default: f_busy = busy4;
        endcase
    endfunction

    function automatic logic f_done(input int w);
        case (w)
            2:       f_done = done2;
            7:       f_done = done7;
            default: f_done = done4;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset;
        @(negedge CLK);
        rstn = 1'b0;
        @(negedge CLK);
        rstn = 1'b1;
    endtask

    // One automatic cycle on the instance of width w; s is loaded MSB first so Q ends equal to s.
    task automatic auto_cycle(input int w, input logic [63:0] d, input logic [63:0] s,
                              input bit noise, input string tag);
        int          busy_cnt;
        logic [63:0] m;
        m        = (64'd1 << w) - 64'd1;
        busy_cnt = 0;
        di       = d;
        se       = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_rise"}, {63'd0, f_busy(w)}, 64'd1);
        busy_cnt += int'(f_busy(w));
        tick();
        busy_cnt += int'(f_busy(w));
        chk({tag, "_capture"}, f_q(w), d & m);
        for (int i = 0; i < w; i++) begin
            chk($sformatf("%s_so%0d", tag, i), {63'd0, f_so(w)}, {63'd0, d[w-1-i]});
            si = s[w-1-i];
            if (noise) begin
                se    = i[0];
                start = (i == 1);
            end
            tick();
            busy_cnt += int'(f_busy(w));
        end
        se    = 1'b0;
        start = 1'b0;
        chk({tag, "_done_pre"}, {63'd0, f_done(w)}, 64'd0);
        tick();
        busy_cnt += int'(f_busy(w));
        chk({tag, "_busy_fall"}, {63'd0, f_busy(w)}, 64'd0);
        chk({tag, "_done_rise"}, {63'd0, f_done(w)}, 64'd1);
        chk({tag, "_q_final"}, f_q(w), s & m);
        chk({tag, "_uq_final"}, f_uq(w), s & m);
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(w + 2));
        tick();
        chk({tag, "_done_fall"}, {63'd0, f_done(w)}, 64'd0);
        chk({tag, "_no_restart"}, {63'd0, f_busy(w)}, 64'd0);
    endtask

    initial begin
        logic [3:0] model;
        logic [3:0] bits;
        int         done_seen;

        rstn  = 1'b1;
        di    = '0;
        si    = 1'b0;
        se    = 1'b0;
        start = 1'b0;

        // Asynchronous reset mid-cycle, checked before any further edge.
        #7;
        rstn = 1'b0;
        #1;
        chk("rst_q", {60'd0, q4}, 64'hA);
        chk("rst_uq", {60'd0, uq4}, 64'hA);
        chk("rst_so", {63'd0, so4}, 64'd1);
        chk("rst_busy", {63'd0, busy4}, 64'd0);
        chk("rst_done", {63'd0, done4}, 64'd0);
        @(negedge CLK);
        rstn = 1'b1;

        // Functional capture.
        di = 64'h6;
        tick();
        chk("func_q0", {60'd0, q4}, 64'h6);
        di = 64'h9;
        tick();
        chk("func_q1", {60'd0, q4}, 64'h9);
        chk("func_uq", {60'd0, uq4}, 64'hA);

        // Manual shift from a cleared chain.
        di = 64'h0;
        tick();
        model = 4'b0000;
        bits  = 4'b1011;
        se    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("man_so%0d", i), {63'd0, so4}, {63'd0, model[3]});
            si    = bits[3-i];
            model = {model[2:0], bits[3-i]};
            tick();
        end
        se = 1'b0;
        chk("man_q", {60'd0, q4}, 64'hB);
        chk("man_so_after", {63'd0, so4}, 64'd1);
        chk("man_uq", {60'd0, uq4}, 64'hA);

        // Automatic cycles at WIDTH 4, then with SE/START disturbance during SHIFT.
        pulse_reset();
        auto_cycle(4, 64'hC, 64'h9, 1'b0, "w4");
        pulse_reset();
        auto_cycle(4, 64'h5, 64'h6, 1'b1, "w4_noise");

        // Abort mid-cycle; UQ holds 4'b0110 from the previous cycle until reset.
        di    = 64'h3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        rstn = 1'b0;
        #1;
        chk("abort_q", {60'd0, q4}, 64'hA);
        chk("abort_uq", {60'd0, uq4}, 64'hA);
        chk("abort_busy", {63'd0, busy4}, 64'd0);
        chk("abort_done", {63'd0, done4}, 64'd0);
        @(negedge CLK);
        rstn      = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            done_seen += int'(done4);
        end
        chk("abort_no_done", 64'(done_seen), 64'd0);
        auto_cycle(4, 64'hE, 64'h1, 1'b0, "w4_post_abort");

        // Counter boundary at other widths.
        pulse_reset();
        auto_cycle(2, 64'h2, 64'h1, 1'b0, "w2");
        pulse_reset();
        auto_cycle(7, 64'h59, 64'h35, 1'b0, "w7");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
